// File: rtl/aes_inv_keysched.sv
// AES-128 reverse key schedule: walks round keys 10 down to 0
// from the last round key, one valid/ready handshake per key.
module aes_inv_keysched (
  input  logic         clk,
  input  logic         rst,
  input  logic         sys_en,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    CALC = 2'd2
  } state_t;

  // Byte 0x00 is the most significant byte of the table.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    logic [10:0] off;
    off = {~b, 3'b000};
    return SBOX[off +: 8];
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    logic [7:0] v;
    unique case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] sub_rot(
    input logic [31:0] w
  );
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]), sbox(r[23:16]),
            sbox(r[15:8]),  sbox(r[7:0])};
  endfunction

  function automatic logic [127:0] inv_step(
    input logic [127:0] k,
    input logic [3:0]   r
  );
    logic [31:0] a0, a1, a2, a3;
    logic [31:0] p0, p1, p2, p3;
    {a0, a1, a2, a3} = k;
    p3 = a3 ^ a2;
    p2 = a2 ^ a1;
    p1 = a1 ^ a0;
    p0 = a0 ^ sub_rot(p3) ^ {rcon(r), 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic         cnt_q, cnt_d;
  logic         done_q, done_d;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (sys_en) begin
      done_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            key_d   = last_key;
            idx_d   = 4'd10;
            state_d = EMIT;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (idx_q == 4'd0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = CALC;
              cnt_d   = 1'b0;
            end
          end
        end
        CALC: begin
          if (!cnt_q) begin
            cnt_d = 1'b1;
          end else begin
            key_d   = inv_step(key_q, idx_q);
            idx_d   = idx_q - 4'd1;
            state_d = EMIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid = (state_q == EMIT);
  assign rk_data  = rk_valid ? key_q : '0;
  assign rk_idx   = rk_valid ? idx_q : '0;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_keysched.sv
// Scoreboard bench for aes_inv_keysched using FIPS-197
// and all-zero-key schedules.
module tb_aes_inv_keysched;

  logic         clk = 1'b0;
  logic         rst;
  logic         sys_en;
  logic         start;
  logic [127:0] last_key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;

  aes_inv_keysched dut (
    .clk      (clk),
    .rst      (rst),
    .sys_en   (sys_en),
    .start    (start),
    .last_key (last_key),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
    bit           chk;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   dq[$];
  int   nvec = 0;
  int   nerr = 0;
  int   nhs = 0;
  int   ndone = 0;

  logic [127:0] fk [0:10];
  logic [127:0] zk10;

  bit           prev_stall = 1'b0;
  logic [127:0] prev_d;
  logic [3:0]   prev_i;

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // which: 0 = FIPS-197 key, 1 = zero key (only ends known)
  task automatic push_exp(input int which, input int n0,
                          input int sk, input int sn,
                          input int upto, input bit wd);
    exp_t e;
    for (int k = 10; k >= upto; k--) begin
      e.idx = 4'(k);
      e.cyc = n0 + 1 + 3 * (10 - k) + ((k <= sk) ? sn : 0);
      if (which == 0) begin
        e.data = fk[k];
        e.chk  = 1'b1;
      end else begin
        e.data = (k == 10) ? zk10 : '0;
        e.chk  = (k == 10) || (k == 0);
      end
      q.push_back(e);
    end
    if (wd) dq.push_back(n0 + 32 + sn);
  endtask

  task automatic kick(input logic [127:0] k,
                      output int n0);
    @(posedge clk); #1;
    last_key = k;
    start    = 1'b1;
    n0       = cyc;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((q.size() != 0 || dq.size() != 0) && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    nvec++;
    if (q.size() != 0 || dq.size() != 0) begin
      nerr++;
      $display("FAIL drain: keys left %0d dones left %0d, want 0 0",
               q.size(), dq.size());
    end
    q.delete();
    dq.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rk_valid && rk_ready && sys_en) begin
        exp_t e;
        nhs++;
        nvec++;
        if (q.size() == 0) begin
          nerr++;
          $display("FAIL hs_unexp: got idx %0d data %h, want none",
                   rk_idx, rk_data);
        end else begin
          e = q.pop_front();
          if (rk_idx !== e.idx || cyc != e.cyc ||
              (e.chk && rk_data !== e.data)) begin
            nerr++;
            $display("FAIL key: got idx %0d data %h cyc %0d, want idx %0d data %h cyc %0d",
                     rk_idx, rk_data, cyc, e.idx, e.data, e.cyc);
          end
        end
      end
      if (done && sys_en) begin
        int dc;
        ndone++;
        nvec++;
        if (dq.size() == 0) begin
          nerr++;
          $display("FAIL done_unexp: got done at cyc %0d, want none", cyc);
        end else begin
          dc = dq.pop_front();
          if (cyc != dc) begin
            nerr++;
            $display("FAIL done_cyc: got %0d want %0d", cyc, dc);
          end
        end
      end
      if (rk_valid && !rk_ready) begin
        if (prev_stall) begin
          nvec++;
          if (rk_data !== prev_d || rk_idx !== prev_i) begin
            nerr++;
            $display("FAIL stall_hold: got idx %0d data %h, want idx %0d data %h",
                     rk_idx, rk_data, prev_i, prev_d);
          end
        end
        prev_stall = 1'b1;
        prev_d     = rk_data;
        prev_i     = rk_idx;
      end else begin
        prev_stall = 1'b0;
      end
      if (!sys_en) begin
        nvec++;
        if (rk_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
          nerr++;
          $display("FAIL freeze: got valid %b busy %b done %b, want 0 1 0",
                   rk_valid, busy, done);
        end
      end
    end
  end

  initial begin
    int n0;
    int h0;
    int d0;
    fk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zk10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    rst      = 1'b1;
    sys_en   = 1'b0;
    start    = 1'b1;
    last_key = fk[10];
    rk_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(rk_valid), 128'h0);
    chk("rst_data", rk_data, 128'h0);
    chk("rst_idx", 128'(rk_idx), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    start  = 1'b0;
    sys_en = 1'b1;
    rst    = 1'b0;

    kick(fk[10], n0);
    push_exp(0, n0, 99, 0, 0, 1'b1);
    drain(60);

    h0 = nhs;
    d0 = ndone;
    kick(zk10, n0);
    push_exp(1, n0, 99, 0, 0, 1'b1);
    drain(60);
    go_to(cyc + 3);
    chk("zero_hs", 128'(nhs - h0), 128'd11);
    chk("zero_done", 128'(ndone - d0), 128'd1);

    kick(fk[10], n0);
    push_exp(0, n0, 7, 5, 0, 1'b1);
    go_to(n0 + 10);
    rk_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rk_ready = 1'b1;
    drain(60);

    kick(fk[10], n0);
    push_exp(0, n0, 4, 3, 0, 1'b1);
    go_to(n0 + 17);
    sys_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sys_en = 1'b1;
    drain(60);

    kick(fk[10], n0);
    push_exp(0, n0, 99, 0, 0, 1'b1);
    go_to(n0 + 5);
    last_key = zk10;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    last_key = fk[10];
    go_to(n0 + 32);
    chk("coincide_done", 128'(done), 128'h1);
    last_key = zk10;
    start    = 1'b1;
    push_exp(1, n0 + 32, 99, 0, 0, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    drain(80);

    kick(fk[10], n0);
    push_exp(0, n0, 99, 0, 5, 1'b0);
    go_to(n0 + 19);
    chk("pre_rst_idx", 128'(rk_idx), 128'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", 128'(rk_valid), 128'h0);
    chk("mid_rst_data", rk_data, 128'h0);
    chk("mid_rst_idx", 128'(rk_idx), 128'h0);
    chk("mid_rst_busy", 128'(busy), 128'h0);
    chk("mid_rst_done", 128'(done), 128'h0);
    repeat (40) @(posedge clk);
    #1;
    chk("mid_rst_idle", 128'(busy), 128'h0);
    drain(5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
